// File: rtl/bcd_complementer_seq_if.sv
// Operand/result bundle for the sequential BCD complementer.
// The requester raises start with mode/bcd_in while busy=0; done pulses once when result is valid.
interface bcd_complementer_seq_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic [1:0]            mode;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   result;
    logic                  carry_out;
    logic                  invalid;
    logic [1:0]            dbg_state;

    modport master (
        output start, mode, bcd_in,
        input  busy, done, result, carry_out, invalid, dbg_state
    );

    modport slave (
        input  start, mode, bcd_in,
        output busy, done, result, carry_out, invalid, dbg_state
    );
endinterface

// File: rtl/bcd_complementer_seq.sv
// Digit-serial pass / nines' / tens' complementer for packed BCD, LSD first.
// Handshake: start is taken only when busy=0; result/invalid/carry_out are final when done=1.
module bcd_complementer_seq #(
    parameter int DIGITS = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    bcd_complementer_seq_if.slave  bus
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t         state;
    logic [W-1:0]   operand_q;
    logic [1:0]     mode_q;
    logic [IW-1:0]  idx;
    logic           carry_q;
    logic [W-1:0]   result_q;
    logic           invalid_q;
    logic           carry_out_q;
    logic           done_q;

    logic [3:0]     d;
    logic [3:0]     nine;
    logic [3:0]     s;
    logic [3:0]     out;
    logic           carry_n;
    logic           bad;
    logic           last;

    assign d    = operand_q[4*int'(idx) +: 4];
    assign nine = 4'd9 - d;
    assign s    = nine + {3'b000, carry_q};
    assign bad  = (d > 4'd9);
    assign last = (idx == IW'(DIGITS - 1));

    always_comb begin
        out     = d;
        carry_n = carry_q;
        case (mode_q)
            2'b01: out = nine;
            2'b10: begin
                if (s == 4'd10) begin
                    out     = 4'd0;
                    carry_n = 1'b1;
                end else begin
                    out     = s;
                    carry_n = 1'b0;
                end
            end
            default: out = d;
        endcase
        // Out-of-range digits poison the complement modes but pass through untouched.
        if (bad && (mode_q == 2'b01 || mode_q == 2'b10)) begin
            out     = 4'd0;
            carry_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            operand_q   <= '0;
            mode_q      <= 2'b00;
            idx         <= '0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            invalid_q   <= 1'b0;
            carry_out_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state       <= RUN;
                        operand_q   <= bus.bcd_in;
                        mode_q      <= bus.mode;
                        idx         <= '0;
                        carry_q     <= (bus.mode == 2'b10);
                        result_q    <= '0;
                        invalid_q   <= 1'b0;
                        carry_out_q <= 1'b0;
                    end
                end
                RUN: begin
                    result_q[4*int'(idx) +: 4] <= out;
                    carry_q <= carry_n;
                    if (bad) invalid_q <= 1'b1;
                    if (last) begin
                        state       <= DONE;
                        done_q      <= 1'b1;
                        carry_out_q <= (mode_q == 2'b10) ? carry_n : 1'b0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.carry_out = carry_out_q;
    assign bus.invalid   = invalid_q;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_bcd_complementer_seq.sv
// Directed-vector bench for bcd_complementer_seq with an expected-result queue and done monitor.
module tb_bcd_complementer_seq;
    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic clk;
    logic rst_n;

    bcd_complementer_seq_if #(.DIGITS(DIGITS)) bus ();

    bcd_complementer_seq #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // {invalid, carry_out, result}
    logic [W+1:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: result 0x%0h with no expectation at %0t", bus.result, $time);
            end else begin
                logic [W+1:0] e;
                e = exp_q.pop_front();
                chk("result",    32'(bus.result),    32'(e[W-1:0]));
                chk("carry_out", 32'(bus.carry_out), 32'(e[W]));
                chk("invalid",   32'(bus.invalid),   32'(e[W+1]));
            end
        end
    end

    task automatic wait_done(output int n);
        bit found;
        n = 0;
        found = 0;
        while (!found && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.done) found = 1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done within %0d edges", n);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_busy"},      32'(bus.busy),      32'd0);
        chk({tag, "_done"},      32'(bus.done),      32'd0);
        chk({tag, "_result"},    32'(bus.result),    32'd0);
        chk({tag, "_carry_out"}, 32'(bus.carry_out), 32'd0);
        chk({tag, "_invalid"},   32'(bus.invalid),   32'd0);
    endtask

    task automatic run_op(input logic [1:0] m, input logic [W-1:0] d,
                          input logic [W-1:0] r, input logic co, input logic inv);
        int n;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.mode   = m;
        bus.bcd_in = d;
        exp_q.push_back({inv, co, r});
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.mode   = 2'($urandom_range(0, 3));
        bus.bcd_in = W'($urandom);
        chk("busy_after_accept", 32'(bus.busy), 32'd1);
        wait_done(n);
        chk("latency_edges", 32'(n + 1), 32'(DIGITS + 1));
        @(posedge clk);
        #1;
        chk("busy_fall", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int n;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.mode   = 2'b00;
        bus.bcd_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_op(2'b01, 16'h1234, 16'h8765, 1'b0, 1'b0);
        run_op(2'b10, 16'h1234, 16'h8766, 1'b0, 1'b0);
        run_op(2'b10, 16'h0100, 16'h9900, 1'b0, 1'b0);
        run_op(2'b10, 16'h0000, 16'h0000, 1'b1, 1'b0);
        run_op(2'b10, 16'h9999, 16'h0001, 1'b0, 1'b0);
        run_op(2'b00, 16'h0907, 16'h0907, 1'b0, 1'b0);
        run_op(2'b11, 16'h4321, 16'h4321, 1'b0, 1'b0);
        run_op(2'b01, 16'h12A4, 16'h8705, 1'b0, 1'b1);
        run_op(2'b01, 16'h0000, 16'h9999, 1'b0, 1'b0);
        run_op(2'b00, 16'h00B0, 16'h00B0, 1'b0, 1'b1);

        // Starts during RUN and during DONE must be ignored.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.mode   = 2'b01;
        bus.bcd_in = 16'h1234;
        exp_q.push_back({1'b0, 1'b0, 16'h8765});
        @(posedge clk); #1;                       // E0
        bus.start = 1'b0;
        @(posedge clk); #1;                       // E1
        bus.start  = 1'b1;
        bus.mode   = 2'b10;
        bus.bcd_in = 16'h9999;
        @(posedge clk); #1;                       // E2
        bus.start = 1'b0;
        @(posedge clk); #1;                       // E3
        @(posedge clk); #1;                       // E4
        chk("ign_done_at_e4", 32'(bus.done), 32'd1);
        bus.start  = 1'b1;
        bus.mode   = 2'b00;
        bus.bcd_in = 16'h5555;
        @(posedge clk); #1;                       // E5
        chk("ign_busy_fall_e5", 32'(bus.busy), 32'd0);
        chk("ign_done_low_e5",  32'(bus.done), 32'd0);
        chk("ign_result_held",  32'(bus.result), 32'h8765);
        bus.start  = 1'b1;
        bus.mode   = 2'b10;
        bus.bcd_in = 16'h0000;
        exp_q.push_back({1'b0, 1'b1, 16'h0000});
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("ign_next_accept", 32'(bus.busy), 32'd1);
        wait_done(n);
        chk("ign_next_latency", 32'(n + 1), 32'(DIGITS + 1));
        @(posedge clk); #1;

        // Reset in the middle of a run aborts without done.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.mode   = 2'b01;
        bus.bcd_in = 16'h1234;
        @(posedge clk); #1;                       // E0
        bus.start = 1'b0;
        @(posedge clk); #1;                       // E1
        @(posedge clk); #1;                       // E2
        rst_n = 1'b0;
        #1;
        check_idle_zero("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("midreset_no_done", 32'(bus.done), 32'd0);
        run_op(2'b10, 16'h0250, 16'h9750, 1'b0, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
